instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Stage-0 producer for the pre-ALU stage. Fetches 32-bit instructions from instruction memory
//  over a req/ack handshake and splits each one into its parts. It looks up microcode from the
//  opcode fields and presents microcode_s0, instruction_data_s0 (instr[31:7]) and pc_s0
//  (word address). Handles pipeline stalls via clk_enable, redirects from later stages, and
//  bubble insertion when no instruction is ready.
// PARAMETERS
//  RESET_PC     30'h0   word address fetched first after reset
// PORTS
//  clk                  in   1   single clock, rising edge
//  rst                  in   1   synchronous, active-high reset
//  clk_enable           in   1   pipeline advance; s0 outputs update only when high
//  redirect_valid       in   1   branch/jump taken; overrides sequential PC
//  redirect_pc          in   30  redirect target (word address)
//  imem_req             out  1   memory request; held until imem_ack
//  imem_addr            out  30  request word address; stable while imem_req high
//  imem_ack             in   1   data valid on imem_rdata this cycle
//  imem_rdata           in   32  instruction word
//  microcode_s0         out  23  microcode word for instruction in s0
//  instruction_data_s0  out  25  instr[31:7] of instruction in s0
//  pc_s0                out  30  word address of instruction in s0
//  valid_s0             out  1   s0 holds a real instruction (0 = bubble)
//  fetch_stall          out  1   high when no instruction is available to load into s0 this cycle
// BEHAVIOUR
//  Reset (rst sampled high at posedge):
//  - state=IDLE, pc=RESET_PC, buffer cleared, imem_req=0.
//  - microcode_s0=NOP_UCODE, instruction_data_s0=0, pc_s0=0, valid_s0=0.
//  - Reset mid-request abandons the transaction; memory is reset together with the core.
//  States (fetch_state_e):
//  - IDLE: imem_req=0; next cycle goes to REQ.
//  - REQ: imem_req=1, imem_addr=pc.
//    - On ack with clk_enable=1, load s0 directly: valid_s0=1, pc<=pc+1, stay in REQ.
//      Ack-to-s0 latency is 1 clk.
//    - On ack with clk_enable=0, store {rdata,pc} in the 1-entry buffer, pc<=pc+1, go to HOLD.
//  - HOLD: imem_req=0. When clk_enable=1, load s0 from the buffer and go to REQ.
//  - DRAIN: a redirect occurred while a request was outstanding. Keep imem_req=1 at the OLD
//    address until ack, discard that data, then go to REQ at the redirected pc.
//  Bubbles:
//  - When clk_enable=1 and no instruction is available (REQ without ack, IDLE, DRAIN), s0 loads
//    microcode_s0=NOP_UCODE, instruction_data_s0=0, valid_s0=0; pc_s0 holds its value.
//  - fetch_stall = !(state==HOLD || (state==REQ && imem_ack)), masked by rst.
//  Redirect (highest priority after rst), in all states:
//  - pc<=redirect_pc and the buffer is invalidated.
//  - If clk_enable=1, s0 takes a bubble.
//  - If in REQ without ack, go to DRAIN.
//  - If in REQ with ack same cycle, the data is dropped and the state goes to REQ (new pc,
//    next cycle).
//  - If in HOLD or IDLE, go to REQ.
//  - A redirect while already in DRAIN updates pc only; draining continues.
//  Arithmetic and decode:
//  - pc+1 wraps modulo 2^30 (30'h3FFFFFFF -> 0).
//  - Microcode lookup is combinational on imem_rdata or the buffer, keyed by
//    {opcode[6:2], funct3, funct7[5]}.
//  - instr[1:0] != 2'b11 or an unmapped key gives ILLEGAL_UCODE with valid_s0=1; a later stage
//    traps on it.
//  - clk_enable=0 freezes all s0 outputs regardless of ack or redirect.
// STRUCTURE
//  core_pkg holds:
//  - fetch_state_e {IDLE, REQ, HOLD, DRAIN}
//  - NOP_UCODE (23'h0), ILLEGAL_UCODE
//  - UCODE_W=23, IDATA_W=25, PC_W=30
//  Sub-module microcode_rom: combinational, 9-bit key -> 23-bit word, ILLEGAL_UCODE default.
//  Shared with any future decoder.
// TESTING
//  1. Reset, ack every cycle, clk_enable=1
//     -> imem_addr 0,1,2,...; pc_s0 trails by 1 clk; valid_s0=1 from the 3rd clk.
//  2. Ack at addr 5 with clk_enable=0 for 3 clks
//     -> state HOLD, imem_req=0, s0 frozen.
//     -> On clk_enable=1: pc_s0=5, next imem_addr=6.
//  3. Redirect to 30'h100 while a request to 7 is pending (ack 2 clks later)
//     -> imem_req stays high at addr 7 until ack, data discarded, then imem_addr=0x100.
//     -> No s0 with pc 7.
//  4. Redirect coincident with ack
//     -> data dropped, valid_s0=0, next imem_addr=redirect_pc.
//  5. Fetch at 30'h3FFFFFFF -> next imem_addr=0.
//     Instr 32'h00000000 (bits[1:0]=00) -> microcode_s0=ILLEGAL_UCODE, valid_s0=1.
//  6. rst asserted while in DRAIN and in HOLD
//     -> next clk: imem_req=0, valid_s0=0, then fetch restarts at RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: fetch FSM states, microcode word layout and opcode keys.
// Used by the fetch stage and by any later decoder reading microcode.
package core_pkg;

    localparam int UCODE_W = 23;
    localparam int IDATA_W = 25;
    localparam int PC_W    = 30;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic       trap;
        logic [3:0] cls;
        logic [3:0] alu_op;
        logic [2:0] funct3;
        logic       wb_en;
        logic [2:0] imm_sel;
        logic       mem_rd;
        logic       mem_wr;
        logic       branch;
        logic       jump;
        logic       src_a_pc;
        logic       src_b_imm;
        logic       rsvd;
    } ucode_t;

    localparam logic [UCODE_W-1:0] NOP_UCODE     = 23'h000000;
    localparam logic [UCODE_W-1:0] ILLEGAL_UCODE = 23'h400000;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_FENCE  = 5'b00011;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    function automatic logic [8:0] ucode_key(input logic [31:0] instr);
        return {instr[6:2], instr[14:12], instr[30]};
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode lookup keyed by {opcode[6:2], funct3, funct7[5]}.
// Any key outside RV32I returns ILLEGAL_UCODE.
module microcode_rom
    import core_pkg::*;
(
    input  logic [8:0]         key,
    output logic [UCODE_W-1:0] ucode
);

    logic [4:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       legal;
    ucode_t     u;

    assign op = key[8:4];
    assign f3 = key[3:1];
    assign f7 = key[0];

    always_comb begin
        u        = '0;
        u.funct3 = f3;
        legal    = 1'b0;
        unique case (op)
            OP_LUI: begin
                legal = 1'b1; u.cls = 4'd1; u.wb_en = 1'b1;
                u.imm_sel = IMM_U; u.src_b_imm = 1'b1;
            end
            OP_AUIPC: begin
                legal = 1'b1; u.cls = 4'd2; u.wb_en = 1'b1;
                u.imm_sel = IMM_U; u.src_a_pc = 1'b1; u.src_b_imm = 1'b1;
            end
            OP_JAL: begin
                legal = 1'b1; u.cls = 4'd3; u.wb_en = 1'b1;
                u.imm_sel = IMM_J; u.jump = 1'b1; u.src_a_pc = 1'b1;
            end
            OP_JALR: begin
                legal = (f3 == 3'd0); u.cls = 4'd4; u.wb_en = 1'b1;
                u.imm_sel = IMM_I; u.jump = 1'b1; u.src_b_imm = 1'b1;
            end
            OP_BRANCH: begin
                legal = (f3 != 3'd2) && (f3 != 3'd3); u.cls = 4'd5;
                u.imm_sel = IMM_B; u.branch = 1'b1;
            end
            OP_LOAD: begin
                legal = (f3 != 3'd3) && (f3 < 3'd6); u.cls = 4'd6;
                u.wb_en = 1'b1; u.imm_sel = IMM_I; u.mem_rd = 1'b1;
                u.src_b_imm = 1'b1;
            end
            OP_STORE: begin
                legal = (f3 < 3'd3); u.cls = 4'd7; u.imm_sel = IMM_S;
                u.mem_wr = 1'b1; u.src_b_imm = 1'b1;
            end
            OP_OPIMM: begin
                legal = (f3 != 3'd1) || !f7; u.cls = 4'd8; u.wb_en = 1'b1;
                u.imm_sel = IMM_I; u.src_b_imm = 1'b1;
                u.alu_op = {(f3 == 3'd5) & f7, f3};
            end
            OP_OP: begin
                legal = !f7 || (f3 == 3'd0) || (f3 == 3'd5);
                u.cls = 4'd9; u.wb_en = 1'b1; u.alu_op = {f7, f3};
            end
            OP_FENCE: begin
                legal = (f3 < 3'd2); u.cls = 4'd10;
            end
            OP_SYSTEM: begin
                legal = 1'b1; u.cls = 4'd11; u.wb_en = (f3 != 3'd0);
                u.imm_sel = IMM_I;
            end
            default: legal = 1'b0;
        endcase
        ucode = legal ? u : ILLEGAL_UCODE;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Stage-0 fetch: req/ack instruction memory client with a one-entry skid
// buffer, redirect draining and bubble insertion into the s0 registers.
module instruction_fetch
    import core_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_enable,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [UCODE_W-1:0] microcode_s0,
    output logic [IDATA_W-1:0] instruction_data_s0,
    output logic [PC_W-1:0]    pc_s0,
    output logic               valid_s0,
    output logic               fetch_stall
);

    fetch_state_e       state;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    addr_q;
    logic               req_q;
    logic               buf_valid;
    logic [31:0]        buf_instr;
    logic [PC_W-1:0]    buf_pc;

    logic [31:0]        sel_instr;
    logic [PC_W-1:0]    sel_pc;
    logic [UCODE_W-1:0] rom_word;
    logic [UCODE_W-1:0] sel_ucode;
    logic               avail;
    logic [PC_W-1:0]    pc_inc;

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign pc_inc    = pc + 30'd1;

    assign sel_instr = (state == HOLD) ? buf_instr : imem_rdata;
    assign sel_pc    = (state == HOLD) ? buf_pc : pc;

    microcode_rom u_rom (
        .key   (ucode_key(sel_instr)),
        .ucode (rom_word)
    );

    // Compressed / reserved encodings are not mapped: trap downstream.
    assign sel_ucode = (sel_instr[1:0] == 2'b11) ? rom_word : ILLEGAL_UCODE;

    assign avail = !redirect_valid &&
                   ((state == REQ && imem_ack) ||
                    (state == HOLD && buf_valid));

    assign fetch_stall = !rst &&
                         !(state == HOLD || (state == REQ && imem_ack));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            addr_q    <= RESET_PC;
            req_q     <= 1'b0;
            buf_valid <= 1'b0;
            buf_instr <= '0;
            buf_pc    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state  <= REQ;
                    req_q  <= 1'b1;
                    addr_q <= redirect_valid ? redirect_pc : pc;
                    if (redirect_valid) pc <= redirect_pc;
                end
                REQ: begin
                    if (redirect_valid) begin
                        pc        <= redirect_pc;
                        buf_valid <= 1'b0;
                        if (imem_ack) addr_q <= redirect_pc;
                        else          state  <= DRAIN;
                    end else if (imem_ack) begin
                        pc <= pc_inc;
                        if (clk_enable) begin
                            addr_q <= pc_inc;
                        end else begin
                            buf_valid <= 1'b1;
                            buf_instr <= imem_rdata;
                            buf_pc    <= pc;
                            state     <= HOLD;
                            req_q     <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid || clk_enable) begin
                        buf_valid <= 1'b0;
                        state     <= REQ;
                        req_q     <= 1'b1;
                        addr_q    <= redirect_valid ? redirect_pc : pc;
                        if (redirect_valid) pc <= redirect_pc;
                    end
                end
                DRAIN: begin
                    // Old address stays on the bus until memory answers.
                    if (redirect_valid) pc <= redirect_pc;
                    if (imem_ack) begin
                        state  <= REQ;
                        addr_q <= redirect_valid ? redirect_pc : pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            microcode_s0        <= NOP_UCODE;
            instruction_data_s0 <= '0;
            pc_s0               <= '0;
            valid_s0            <= 1'b0;
        end else if (clk_enable) begin
            if (avail) begin
                microcode_s0        <= sel_ucode;
                instruction_data_s0 <= sel_instr[31:7];
                pc_s0               <= sel_pc;
                valid_s0            <= 1'b1;
            end else begin
                microcode_s0        <= NOP_UCODE;
                instruction_data_s0 <= '0;
                valid_s0            <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a combinational-ack memory model.
module tb_instruction_fetch;
    import core_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               clk_enable;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [31:0]        imem_rdata;
    logic [UCODE_W-1:0] microcode_s0;
    logic [IDATA_W-1:0] instruction_data_s0;
    logic [PC_W-1:0]    pc_s0;
    logic               valid_s0;
    logic               fetch_stall;

    logic               ack_en;
    logic               force_en;
    logic [31:0]        force_word;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [22:0] UC_ADDI = 23'h200482;
    localparam logic [22:0] UC_SUB  = 23'h260400;
    localparam logic [22:0] UC_ILL  = 23'h400000;

    always #5 clk = ~clk;

    // Default memory word at address a: addi-class, instr[31:7] = a[24:0].
    assign imem_ack   = ack_en & imem_req;
    assign imem_rdata = force_en ? force_word : {imem_addr[24:0], 7'b0010011};

    instruction_fetch #(.RESET_PC(30'h0)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .clk_enable          (clk_enable),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_ack            (imem_ack),
        .imem_rdata          (imem_rdata),
        .microcode_s0        (microcode_s0),
        .instruction_data_s0 (instruction_data_s0),
        .pc_s0               (pc_s0),
        .valid_s0            (valid_s0),
        .fetch_stall         (fetch_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clk_enable = 1'b1; redirect_valid = 1'b0;
        redirect_pc = '0; ack_en = 1'b1; force_en = 1'b0; force_word = '0;
        tick();
        tick();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(valid_s0), 32'd0);
        check("rst_ucode", 32'(microcode_s0), 32'(NOP_UCODE));
        check("rst_pc", 32'(pc_s0), 32'd0);
        check("rst_idata", 32'(instruction_data_s0), 32'd0);
        rst = 1'b0;

        tick();
        check("t1_req", 32'(imem_req), 32'd1);
        check("t1_addr0", 32'(imem_addr), 32'd0);
        check("t1_valid0", 32'(valid_s0), 32'd0);
        check("t1_stall", 32'(fetch_stall), 32'd0);
        tick();
        check("t1_valid", 32'(valid_s0), 32'd1);
        check("t1_pc0", 32'(pc_s0), 32'd0);
        check("t1_addr1", 32'(imem_addr), 32'd1);
        check("t1_ucode", 32'(microcode_s0), 32'(UC_ADDI));
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t1_pc", 32'(pc_s0), 32'(k));
            check("t1_addr", 32'(imem_addr), 32'(k + 1));
            check("t1_idata", 32'(instruction_data_s0), 32'(k));
        end

        clk_enable = 1'b0;
        tick();
        check("t2_req", 32'(imem_req), 32'd0);
        check("t2_frz_pc", 32'(pc_s0), 32'd4);
        check("t2_stall", 32'(fetch_stall), 32'd0);
        tick();
        tick();
        check("t2_req3", 32'(imem_req), 32'd0);
        check("t2_frz3", 32'(pc_s0), 32'd4);
        check("t2_frzv", 32'(valid_s0), 32'd1);
        clk_enable = 1'b1;
        tick();
        check("t2_pc5", 32'(pc_s0), 32'd5);
        check("t2_idata", 32'(instruction_data_s0), 32'd5);
        check("t2_ucode", 32'(microcode_s0), 32'(UC_ADDI));
        check("t2_addr6", 32'(imem_addr), 32'd6);
        check("t2_req1", 32'(imem_req), 32'd1);

        tick();
        check("t3_pc6", 32'(pc_s0), 32'd6);
        check("t3_addr7", 32'(imem_addr), 32'd7);
        ack_en = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 30'h100;
        tick();
        redirect_valid = 1'b0;
        check("t3_dreq", 32'(imem_req), 32'd1);
        check("t3_daddr", 32'(imem_addr), 32'd7);
        check("t3_bub", 32'(valid_s0), 32'd0);
        check("t3_stall", 32'(fetch_stall), 32'd1);
        tick();
        check("t3_daddr2", 32'(imem_addr), 32'd7);
        check("t3_dreq2", 32'(imem_req), 32'd1);
        ack_en = 1'b1;
        tick();
        check("t3_nov", 32'(valid_s0), 32'd0);
        check("t3_pchold", 32'(pc_s0), 32'd6);
        check("t3_newaddr", 32'(imem_addr), 32'h100);
        tick();
        check("t3_pc100", 32'(pc_s0), 32'h100);
        check("t3_v100", 32'(valid_s0), 32'd1);

        redirect_valid = 1'b1; redirect_pc = 30'h200;
        tick();
        redirect_valid = 1'b0;
        check("t4_bub", 32'(valid_s0), 32'd0);
        check("t4_addr", 32'(imem_addr), 32'h200);
        check("t4_pchold", 32'(pc_s0), 32'h100);
        tick();
        check("t4_pc200", 32'(pc_s0), 32'h200);

        redirect_valid = 1'b1; redirect_pc = 30'h3FFFFFFF;
        tick();
        redirect_valid = 1'b0;
        check("t5_addrmax", 32'(imem_addr), 32'h3FFFFFFF);
        force_en = 1'b1; force_word = 32'h00000000;
        tick();
        check("t5_pcmax", 32'(pc_s0), 32'h3FFFFFFF);
        check("t5_ill", 32'(microcode_s0), 32'(UC_ILL));
        check("t5_illv", 32'(valid_s0), 32'd1);
        check("t5_wrap", 32'(imem_addr), 32'd0);
        force_word = 32'h40000033;
        tick();
        check("t5_subpc", 32'(pc_s0), 32'd0);
        check("t5_sub", 32'(microcode_s0), 32'(UC_SUB));
        force_word = 32'h00002063;
        tick();
        check("t5_unmap", 32'(microcode_s0), 32'(UC_ILL));
        check("t5_unmapv", 32'(valid_s0), 32'd1);
        force_en = 1'b0;

        ack_en = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 30'h50;
        tick();
        redirect_valid = 1'b0;
        check("t6_dreq", 32'(imem_req), 32'd1);
        check("t6_daddr", 32'(imem_addr), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rreq", 32'(imem_req), 32'd0);
        check("t6_rvalid", 32'(valid_s0), 32'd0);
        tick();
        check("t6_restart", 32'(imem_req), 32'd1);
        check("t6_raddr", 32'(imem_addr), 32'd0);
        ack_en = 1'b1; clk_enable = 1'b0;
        tick();
        check("t6_hreq", 32'(imem_req), 32'd0);
        rst = 1'b1; clk_enable = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_hrreq", 32'(imem_req), 32'd0);
        check("t6_hrvalid", 32'(valid_s0), 32'd0);
        tick();
        check("t6_hraddr", 32'(imem_addr), 32'd0);
        tick();
        check("t6_hrpc", 32'(pc_s0), 32'd0);
        check("t6_hrv", 32'(valid_s0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
